// File: rtl/conv3x3_pkg.sv
// Shared constants, state encoding and helpers for the 3x3 convolution
// window serializer.
package conv3x3_pkg;

    localparam int N_TAP     = 9;
    localparam int TAP_IDX_W = 4;

    // State encoding kept as plain constants so older blocks can share it.
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t STREAM = 2'd1;
    localparam state_t GAP    = 2'd2;

    // True on the final tap of a window.
    function automatic logic is_last_tap(input logic [TAP_IDX_W-1:0] idx);
        return idx == TAP_IDX_W'(N_TAP - 1);
    endfunction

endpackage

// File: rtl/conv3x3_tap_mux.sv
// N_TAP:1 selector of packed {pixel, weight} pairs, indexed by the tap index.
// An out-of-range index selects zero.
module conv3x3_tap_mux #(
    parameter int N_TAP = 9,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int SEL_W = 4
) (
    input  logic [N_TAP*(DW+WW)-1:0] pairs,
    input  logic [SEL_W-1:0]         sel,
    output logic [DW+WW-1:0]         pair_sel
);

    // Pick the pair whose position matches sel.
    always_comb begin
        pair_sel = '0;
        for (int i = 0; i < N_TAP; i++) begin
            if (sel == SEL_W'(i)) begin
                pair_sel = pairs[i*(DW+WW) +: (DW+WW)];
            end
        end
    end

endmodule

// File: rtl/conv3x3_win_ser.sv
// Window serializer: captures a 3x3 pixel window and a 3x3 weight set, then
// streams (pixel, weight) pairs one tap per cycle. Each 9-beat burst is
// followed by one GAP cycle in which the downstream tap counter completes.
module conv3x3_win_ser #(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int N_TAP = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                win_vld,
    output logic                win_rdy,
    input  logic [N_TAP*DW-1:0] win_data,
    input  logic                wgt_vld,
    output logic                wgt_rdy,
    input  logic [N_TAP*WW-1:0] wgt_data,
    output logic                wgt_loaded,
    output logic [DW-1:0]       px,
    output logic [WW-1:0]       wt,
    output logic [3:0]          tap_idx,
    output logic                out_vld,
    output logic                last
);

    import conv3x3_pkg::*;

    state_t                     state;
    logic [N_TAP*DW-1:0]        win_q;
    logic [N_TAP*WW-1:0]        wgt_q;
    logic [N_TAP*(DW+WW)-1:0]   pairs;
    logic [DW+WW-1:0]           pair_sel;
    logic                       win_fire;
    logic                       wgt_fire;

    // Both inputs are blocked while a burst is streaming; a window also
    // needs a weight set to have been loaded first.
    assign wgt_rdy  = (state != STREAM);
    assign win_rdy  = wgt_loaded && (state != STREAM);
    assign wgt_fire = wgt_vld && wgt_rdy;
    assign win_fire = win_vld && win_rdy;

    assign out_vld  = (state == STREAM);
    assign last     = (state == STREAM) && is_last_tap(tap_idx);

    // Capture the weight set and window on their handshakes; a simultaneous
    // capture lets a new weight set apply to the window taken with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= '0;
            wgt_q      <= '0;
            wgt_loaded <= 1'b0;
        end else begin
            if (wgt_fire) begin
                wgt_q      <= wgt_data;
                wgt_loaded <= 1'b1;
            end
            if (win_fire) begin
                win_q <= win_data;
            end
        end
    end

    // Burst sequencing: IDLE waits for a window, STREAM walks taps 0..8,
    // GAP is a single idle cycle that may chain straight into the next burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tap_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_fire) begin
                        state   <= STREAM;
                        tap_idx <= '0;
                    end
                end
                STREAM: begin
                    if (is_last_tap(tap_idx)) begin
                        state   <= GAP;
                        tap_idx <= '0;
                    end else begin
                        tap_idx <= tap_idx + 4'd1;
                    end
                end
                GAP: begin
                    tap_idx <= '0;
                    state   <= win_fire ? STREAM : IDLE;
                end
                default: begin
                    state   <= IDLE;
                    tap_idx <= '0;
                end
            endcase
        end
    end

    // Pair each pixel with its weight so one selector serves both outputs.
    for (genvar i = 0; i < N_TAP; i++) begin : g_pair
        assign pairs[i*(DW+WW) +: (DW+WW)] = {win_q[i*DW +: DW], wgt_q[i*WW +: WW]};
    end

    conv3x3_tap_mux #(
        .N_TAP (N_TAP),
        .DW    (DW),
        .WW    (WW),
        .SEL_W (4)
    ) u_tap_mux (
        .pairs    (pairs),
        .sel      (tap_idx),
        .pair_sel (pair_sel)
    );

    assign px = pair_sel[DW+WW-1:WW];
    assign wt = pair_sel[WW-1:0];

endmodule

// File: tb/tb_conv3x3_win_ser.sv
// Directed bench for conv3x3_win_ser with a behavioural downstream tap
// counter (CNT_MAX=9) that flags completion in the cycle after a burst.
module tb_conv3x3_win_ser;

    logic        clk = 1'b0;
    logic        rst;
    logic        win_vld;
    logic        win_rdy;
    logic [71:0] win_data;
    logic        wgt_vld;
    logic        wgt_rdy;
    logic [71:0] wgt_data;
    logic        wgt_loaded;
    logic [7:0]  px;
    logic [7:0]  wt;
    logic [3:0]  tap_idx;
    logic        out_vld;
    logic        last;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int cnt        = 0;
    int done_count = 0;
    int start_a, start_b, start_c;
    logic tc_done;

    conv3x3_win_ser #(.DW(8), .WW(8), .N_TAP(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .win_vld    (win_vld),
        .win_rdy    (win_rdy),
        .win_data   (win_data),
        .wgt_vld    (wgt_vld),
        .wgt_rdy    (wgt_rdy),
        .wgt_data   (wgt_data),
        .wgt_loaded (wgt_loaded),
        .px         (px),
        .wt         (wt),
        .tap_idx    (tap_idx),
        .out_vld    (out_vld),
        .last       (last)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle stamp used to measure burst spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream tap counter model: counts beats, reports done when idle at 9.
    assign tc_done = !out_vld && (cnt == 9);
    always @(posedge clk) begin
        if (rst)          cnt <= 0;
        else if (out_vld) cnt <= cnt + 1;
        else              cnt <= 0;
        if (tc_done) done_count <= done_count + 1;
    end

    // Nine consecutive byte values starting at base, tap 0 in the low byte.
    function automatic logic [71:0] seq_bus(input int base);
        logic [71:0] b;
        for (int i = 0; i < 9; i++) b[i*8 +: 8] = 8'(base + i);
        return b;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wv, input logic [71:0] wd,
                                 input logic gv, input logic [71:0] gd);
        win_vld  = wv;
        win_data = wd;
        wgt_vld  = gv;
        wgt_data = gd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Checks n_beats streaming beats from the current cycle; optionally
    // pulses wgt_vld with a new weight set mid-burst.
    task automatic checkBurst(input int pbase, input int wbase, input int n_beats,
                              input bit pulse_wgt);
        for (int k = 0; k < n_beats; k++) begin
            checkOutput($sformatf("out_vld[%0d]", k), 32'(out_vld), 32'd1);
            checkOutput($sformatf("px[%0d]", k), 32'(px), 32'(pbase + k));
            checkOutput($sformatf("wt[%0d]", k), 32'(wt), 32'(wbase + k));
            checkOutput($sformatf("tap_idx[%0d]", k), 32'(tap_idx), 32'(k));
            checkOutput($sformatf("last[%0d]", k), 32'(last), 32'(k == 8));
            checkOutput($sformatf("rdy_in_stream[%0d]", k), 32'({win_rdy, wgt_rdy}), 32'd0);
            checkOutput($sformatf("tc_done_beat[%0d]", k), 32'(tc_done), 32'd0);
            if (pulse_wgt && k == 3) begin
                wgt_vld  = 1'b1;
                wgt_data = seq_bus(101);
            end
            if (pulse_wgt && k == 4) wgt_vld = 1'b0;
            tick();
        end
    endtask

    task automatic checkGap(input logic exp_win_rdy);
        checkOutput("gap_out_vld", 32'(out_vld), 32'd0);
        checkOutput("gap_last", 32'(last), 32'd0);
        checkOutput("gap_tap_idx", 32'(tap_idx), 32'd0);
        checkOutput("gap_wgt_rdy", 32'(wgt_rdy), 32'd1);
        checkOutput("gap_win_rdy", 32'(win_rdy), 32'(exp_win_rdy));
        checkOutput("gap_tc_done", 32'(tc_done), 32'd1);
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_win_rdy", 32'(win_rdy), 32'd0);
        checkOutput("rst_wgt_rdy", 32'(wgt_rdy), 32'd1);
        checkOutput("rst_wgt_loaded", 32'(wgt_loaded), 32'd0);
        checkOutput("rst_out_vld", 32'(out_vld), 32'd0);
        checkOutput("rst_last", 32'(last), 32'd0);
        checkOutput("rst_px", 32'(px), 32'd0);
        checkOutput("rst_wt", 32'(wt), 32'd0);
        checkOutput("rst_tap_idx", 32'(tap_idx), 32'd0);
        rst = 1'b0;

        // Window offered before any weights: never accepted
        applyStimulus(1'b1, seq_bus(10), 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("noweight_win_rdy", 32'(win_rdy), 32'd0);
            checkOutput("noweight_out_vld", 32'(out_vld), 32'd0);
        end

        // Load weights 1..9 while the window is still offered
        applyStimulus(1'b1, seq_bus(10), 1'b1, seq_bus(1));
        tick();
        checkOutput("load_wgt_loaded", 32'(wgt_loaded), 32'd1);
        checkOutput("load_win_rdy", 32'(win_rdy), 32'd1);
        checkOutput("load_out_vld", 32'(out_vld), 32'd0);
        applyStimulus(1'b1, seq_bus(10), 1'b0, seq_bus(1));
        tick();
        applyStimulus(1'b0, seq_bus(10), 1'b0, seq_bus(1));
        checkBurst(10, 1, 9, 1'b0);
        checkGap(1'b1);
        tick();
        checkOutput("idle_out_vld", 32'(out_vld), 32'd0);
        checkOutput("idle_win_rdy", 32'(win_rdy), 32'd1);

        // Three back-to-back windows with win_vld held high
        applyStimulus(1'b1, seq_bus(20), 1'b0, seq_bus(1));
        tick();
        start_a = cyc;
        applyStimulus(1'b1, seq_bus(30), 1'b0, seq_bus(1));
        checkBurst(20, 1, 9, 1'b0);
        checkGap(1'b1);
        tick();
        start_b = cyc;
        applyStimulus(1'b1, seq_bus(40), 1'b0, seq_bus(1));
        checkBurst(30, 1, 9, 1'b0);
        checkGap(1'b1);
        tick();
        start_c = cyc;
        applyStimulus(1'b0, seq_bus(40), 1'b0, seq_bus(1));
        checkBurst(40, 1, 9, 1'b0);
        checkGap(1'b1);
        tick();
        checkOutput("spacing_ab", 32'(start_b - start_a), 32'd10);
        checkOutput("spacing_bc", 32'(start_c - start_b), 32'd10);
        checkOutput("b2b_idle_out_vld", 32'(out_vld), 32'd0);

        // Weight pulse mid-stream is ignored for this and the next burst
        applyStimulus(1'b1, seq_bus(50), 1'b0, seq_bus(1));
        tick();
        applyStimulus(1'b1, seq_bus(60), 1'b0, seq_bus(1));
        checkBurst(50, 1, 9, 1'b1);
        checkGap(1'b1);
        tick();
        // New weights offered through the burst, captured in GAP with window 70
        applyStimulus(1'b1, seq_bus(70), 1'b1, seq_bus(101));
        checkBurst(60, 1, 9, 1'b0);
        checkGap(1'b1);
        tick();
        applyStimulus(1'b0, seq_bus(70), 1'b0, seq_bus(101));
        checkBurst(70, 101, 9, 1'b0);
        checkGap(1'b1);
        tick();

        // Reset at tap 4 drops the burst and the weight set
        applyStimulus(1'b1, seq_bus(80), 1'b0, seq_bus(101));
        tick();
        applyStimulus(1'b0, seq_bus(80), 1'b0, seq_bus(101));
        checkBurst(80, 101, 4, 1'b0);
        checkOutput("pre_rst_tap_idx", 32'(tap_idx), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_out_vld", 32'(out_vld), 32'd0);
        checkOutput("midrst_tap_idx", 32'(tap_idx), 32'd0);
        checkOutput("midrst_wgt_loaded", 32'(wgt_loaded), 32'd0);
        checkOutput("midrst_win_rdy", 32'(win_rdy), 32'd0);
        checkOutput("midrst_px", 32'(px), 32'd0);
        checkOutput("midrst_wt", 32'(wt), 32'd0);
        checkOutput("midrst_last", 32'(last), 32'd0);
        applyStimulus(1'b1, seq_bus(90), 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("postrst_out_vld", 32'(out_vld), 32'd0);
            checkOutput("postrst_win_rdy", 32'(win_rdy), 32'd0);
        end

        // Reload weights 5..13: burst begins two cycles after the weight edge
        applyStimulus(1'b1, seq_bus(90), 1'b1, seq_bus(5));
        tick();
        applyStimulus(1'b1, seq_bus(90), 1'b0, seq_bus(5));
        checkOutput("reload_out_vld", 32'(out_vld), 32'd0);
        checkOutput("reload_win_rdy", 32'(win_rdy), 32'd1);
        tick();
        applyStimulus(1'b0, seq_bus(90), 1'b0, seq_bus(5));
        checkBurst(90, 5, 9, 1'b0);
        checkGap(1'b1);
        tick();

        // One counter completion per finished window
        checkOutput("done_count", 32'(done_count), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
